// File: rtl/hr_bridge_nch_pkg.sv
// Shared definitions for the hierarchical-ring bridge: flit field helpers,
// FIFO pointer sizing, the output-source selector and deflection counter width.
package hr_bridge_nch_pkg;

    localparam int DEFL_CNT_W = 16;
    localparam logic [DEFL_CNT_W-1:0] DEFL_CNT_MAX = '1;

    typedef enum logic [1:0] {
        SRC_NONE = 2'd0,
        SRC_PASS = 2'd1,
        SRC_FIFO = 2'd2
    } out_src_e;

    // The valid flag is always the top bit of a flit.
    function automatic int valid_bit(input int flit_w);
        return flit_w - 1;
    endfunction

    // A depth-2 FIFO still needs a 1-bit pointer.
    function automatic int ptr_w(input int depth);
        return (depth <= 2) ? 1 : $clog2(depth);
    endfunction

endpackage

// File: rtl/hrb_xfer_fifo.sv
// Per-channel transfer FIFO between the local and global rings. Fullness is
// evaluated on cycle-start occupancy, so a same-cycle pop never admits a push when full.
module hrb_xfer_fifo
    import hr_bridge_nch_pkg::*;
#(
    parameter int FLIT_W = 144,
    parameter int DEPTH  = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_push,
    input  logic [FLIT_W-1:0] i_data,
    input  logic              i_pop,
    output logic [FLIT_W-1:0] o_head,
    output logic              o_full,
    output logic              o_empty
);

    localparam int PTR_W = ptr_w(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [FLIT_W-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0]  r_wr_ptr;
    logic [PTR_W-1:0]  r_rd_ptr;
    logic [CNT_W-1:0]  r_count;
    logic              w_push;
    logic              w_pop;

    assign o_full  = (r_count == CNT_W'(DEPTH));
    assign o_empty = (r_count == '0);
    assign w_push  = i_push && !o_full;
    assign w_pop   = i_pop && !o_empty;

    // Head is read combinationally; the bridge registers it on the ring output.
    assign o_head = r_mem[r_rd_ptr];

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/hr_bridge_nch.sv
// Local/global ring bridge with NCH independent channels, deflecting flits when
// the transfer FIFO is full. Define HRB_DEFLECT_CNT_EN to add defl_cnt_o counters.
module hr_bridge_nch
    import hr_bridge_nch_pkg::*;
#(
    parameter int FLIT_W   = 144,
    parameter int NCH      = 2,
    parameter int DEPTH    = 4,
    parameter int RING_LSB = 4,
    parameter int RING_W   = 2,
    parameter int MY_RING  = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NCH*FLIT_W-1:0] port_l_i,
    input  logic [NCH*FLIT_W-1:0] port_g_i,
    output logic [NCH*FLIT_W-1:0] port_l_o,
    output logic [NCH*FLIT_W-1:0] port_g_o,
    output logic [NCH-1:0]        l2g_full_o,
    output logic [NCH-1:0]        g2l_full_o
`ifdef HRB_DEFLECT_CNT_EN
    ,
    output logic [NCH*DEFL_CNT_W-1:0] defl_cnt_o
`endif
);

    localparam int VLD = valid_bit(FLIT_W);
    localparam logic [RING_W-1:0] MY_RING_ID = RING_W'(MY_RING);

    genvar gi;
    generate
        for (gi = 0; gi < NCH; gi++) begin : g_ch
            logic [FLIT_W-1:0] w_l_in;
            logic [FLIT_W-1:0] w_g_in;
            logic [FLIT_W-1:0] w_l2g_head;
            logic [FLIT_W-1:0] w_g2l_head;
            logic [FLIT_W-1:0] w_l_next;
            logic [FLIT_W-1:0] w_g_next;
            logic [RING_W-1:0] w_l_dst;
            logic [RING_W-1:0] w_g_dst;
            logic              w_l_vld;
            logic              w_g_vld;
            logic              w_l_xfer;
            logic              w_g_xfer;
            logic              w_l_push;
            logic              w_g_push;
            logic              w_l_pass;
            logic              w_g_pass;
            logic              w_l2g_pop;
            logic              w_g2l_pop;
            logic              w_l2g_full;
            logic              w_g2l_full;
            logic              w_l2g_empty;
            logic              w_g2l_empty;
            out_src_e          w_l_src;
            out_src_e          w_g_src;
            logic [FLIT_W-1:0] r_l_out;
            logic [FLIT_W-1:0] r_g_out;

            assign w_l_in  = port_l_i[gi*FLIT_W +: FLIT_W];
            assign w_g_in  = port_g_i[gi*FLIT_W +: FLIT_W];
            assign w_l_vld = w_l_in[VLD];
            assign w_g_vld = w_g_in[VLD];
            assign w_l_dst = w_l_in[RING_LSB +: RING_W];
            assign w_g_dst = w_g_in[RING_LSB +: RING_W];

            // Local flits leave for another ring; global flits addressed here eject.
            assign w_l_xfer = w_l_vld && (w_l_dst != MY_RING_ID);
            assign w_g_xfer = w_g_vld && (w_g_dst == MY_RING_ID);
            assign w_l_push = w_l_xfer && !w_l2g_full;
            assign w_g_push = w_g_xfer && !w_g2l_full;
            assign w_l_pass = w_l_vld && !w_l_push;
            assign w_g_pass = w_g_vld && !w_g_push;

            // A passing flit owns the slot; otherwise the opposite FIFO may inject.
            always_comb begin
                w_l_src  = SRC_NONE;
                w_g_src  = SRC_NONE;
                w_l_next = '0;
                w_g_next = '0;
                if (w_l_pass) begin
                    w_l_src = SRC_PASS;
                end else if (!w_g2l_empty) begin
                    w_l_src = SRC_FIFO;
                end
                if (w_g_pass) begin
                    w_g_src = SRC_PASS;
                end else if (!w_l2g_empty) begin
                    w_g_src = SRC_FIFO;
                end
                case (w_l_src)
                    SRC_PASS: w_l_next = w_l_in;
                    SRC_FIFO: w_l_next = w_g2l_head;
                    default:  w_l_next = '0;
                endcase
                case (w_g_src)
                    SRC_PASS: w_g_next = w_g_in;
                    SRC_FIFO: w_g_next = w_l2g_head;
                    default:  w_g_next = '0;
                endcase
            end

            assign w_g2l_pop = (w_l_src == SRC_FIFO);
            assign w_l2g_pop = (w_g_src == SRC_FIFO);

            hrb_xfer_fifo #(
                .FLIT_W (FLIT_W),
                .DEPTH  (DEPTH)
            ) u_l2g (
                .clk     (clk),
                .rst     (rst),
                .i_push  (w_l_push),
                .i_data  (w_l_in),
                .i_pop   (w_l2g_pop),
                .o_head  (w_l2g_head),
                .o_full  (w_l2g_full),
                .o_empty (w_l2g_empty)
            );

            hrb_xfer_fifo #(
                .FLIT_W (FLIT_W),
                .DEPTH  (DEPTH)
            ) u_g2l (
                .clk     (clk),
                .rst     (rst),
                .i_push  (w_g_push),
                .i_data  (w_g_in),
                .i_pop   (w_g2l_pop),
                .o_head  (w_g2l_head),
                .o_full  (w_g2l_full),
                .o_empty (w_g2l_empty)
            );

            always_ff @(posedge clk) begin
                if (rst) begin
                    r_l_out <= '0;
                    r_g_out <= '0;
                end else begin
                    r_l_out <= w_l_next;
                    r_g_out <= w_g_next;
                end
            end

            assign port_l_o[gi*FLIT_W +: FLIT_W] = r_l_out;
            assign port_g_o[gi*FLIT_W +: FLIT_W] = r_g_out;
            assign l2g_full_o[gi] = w_l2g_full;
            assign g2l_full_o[gi] = w_g2l_full;

`ifdef HRB_DEFLECT_CNT_EN
            // Both sides of a channel may deflect in the same cycle, so step by up to 2.
            logic [1:0]            w_defl_inc;
            logic [DEFL_CNT_W:0]   w_defl_sum;
            logic [DEFL_CNT_W-1:0] r_defl_cnt;

            assign w_defl_inc = {1'b0, w_l_xfer && w_l2g_full}
                              + {1'b0, w_g_xfer && w_g2l_full};
            assign w_defl_sum = {1'b0, r_defl_cnt}
                              + {{(DEFL_CNT_W-1){1'b0}}, w_defl_inc};

            always_ff @(posedge clk) begin
                if (rst) begin
                    r_defl_cnt <= '0;
                end else if (w_defl_sum[DEFL_CNT_W]) begin
                    r_defl_cnt <= DEFL_CNT_MAX;
                end else begin
                    r_defl_cnt <= w_defl_sum[DEFL_CNT_W-1:0];
                end
            end

            assign defl_cnt_o[gi*DEFL_CNT_W +: DEFL_CNT_W] = r_defl_cnt;
`endif
        end
    endgenerate

endmodule

// File: tb/tb_hr_bridge_nch.sv
// Directed testbench for hr_bridge_nch at default parameters (NCH=2, DEPTH=4, MY_RING=0).
module tb_hr_bridge_nch;

    localparam int W = 144;
    typedef logic [W-1:0]   flit_t;
    typedef logic [2*W-1:0] bus_t;

    logic clk = 1'b0;
    logic rst;
    bus_t port_l_i;
    bus_t port_g_i;
    bus_t port_l_o;
    bus_t port_g_o;
    logic [1:0] l2g_full_o;
    logic [1:0] g2l_full_o;
`ifdef HRB_DEFLECT_CNT_EN
    logic [31:0] defl_cnt_o;
`endif

    int nvec = 0;
    int nerr = 0;

    always #5 clk = ~clk;

    hr_bridge_nch dut (
        .clk        (clk),
        .rst        (rst),
        .port_l_i   (port_l_i),
        .port_g_i   (port_g_i),
        .port_l_o   (port_l_o),
        .port_g_o   (port_g_o),
        .l2g_full_o (l2g_full_o),
        .g2l_full_o (g2l_full_o)
`ifdef HRB_DEFLECT_CNT_EN
        ,
        .defl_cnt_o (defl_cnt_o)
`endif
    );

    // Valid flit with destination ring in [5:4] and a tag in the payload.
    function automatic flit_t mk(input logic [1:0] ring, input logic [15:0] tag);
        flit_t f;
        f = '0;
        f[W-1]    = 1'b1;
        f[5:4]    = ring;
        f[23:8]   = tag;
        f[W-2 -: 16] = ~tag;
        return f;
    endfunction

    function automatic bus_t pk(input flit_t c1, input flit_t c0);
        return {c1, c0};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_bus(input string name, input bus_t got, input bus_t exp);
        nvec++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s got=%h exp=%h", name, got, exp);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        port_l_i = pk(mk(2'd1, 16'hA001), mk(2'd2, 16'hA000));
        port_g_i = pk(mk(2'd0, 16'hA011), mk(2'd0, 16'hA010));
        step();
        step();
        nvec++;
        if (port_l_o !== '0) begin nerr++; $display("FAIL reset_l got=%h exp=0", port_l_o); end
        nvec++;
        if (port_g_o !== '0) begin nerr++; $display("FAIL reset_g got=%h exp=0", port_g_o); end
        nvec++;
        if ({l2g_full_o, g2l_full_o} !== 4'b0) begin
            nerr++; $display("FAIL reset_full got=%b exp=0000", {l2g_full_o, g2l_full_o});
        end
`ifdef HRB_DEFLECT_CNT_EN
        nvec++;
        if (defl_cnt_o !== 32'd0) begin nerr++; $display("FAIL reset_cnt got=%h exp=0", defl_cnt_o); end
`endif
        rst = 1'b0;
        port_l_i = '0;
        port_g_i = '0;
        step();
        step();
        nvec++;
        if ({port_l_o, port_g_o} !== '0) begin
            nerr++; $display("FAIL reset_ignored got_l=%h got_g=%h exp=0", port_l_o, port_g_o);
        end
        $display("test_reset done");
    endtask

    task automatic test_cross_ring();
        flit_t a;
        a = mk(2'd1, 16'h0011);
        port_l_i = pk('0, a);
        step();
        port_l_i = '0;
        chk_bus("cross_g_t1", port_g_o, '0);
        chk_bus("cross_l_t1", port_l_o, '0);
        step();
        chk_bus("cross_g_t2", port_g_o, pk('0, a));
        chk_bus("cross_l_t2", port_l_o, '0);
        step();
        chk_bus("cross_g_t3", port_g_o, '0);
        $display("test_cross_ring done");
    endtask

    task automatic test_local_pass();
        flit_t a;
        flit_t b;
        a = mk(2'd0, 16'h0022);
        b = mk(2'd1, 16'h0023);
        port_l_i = pk('0, a);
        port_g_i = pk(b, '0);
        step();
        port_l_i = '0;
        port_g_i = '0;
        chk_bus("pass_l", port_l_o, pk('0, a));
        chk_bus("pass_g", port_g_o, pk(b, '0));
        step();
        chk_bus("pass_l_after", port_l_o, '0);
        chk_bus("pass_g_after", port_g_o, '0);
        $display("test_local_pass done");
    endtask

    task automatic test_full_deflect(output flit_t q [4]);
        flit_t a;
        flit_t g;
        for (int k = 0; k < 5; k++) begin
            a = mk(2'd1, 16'h0031 + 16'(k));
            g = mk(2'd2, 16'h0041 + 16'(k));
            if (k < 4) q[k] = a;
            port_l_i = pk(a, '0);
            port_g_i = pk(g, '0);
            step();
            chk_bus($sformatf("full_g_k%0d", k), port_g_o, pk(g, '0));
            chk_bus($sformatf("full_l_k%0d", k), port_l_o, (k == 4) ? pk(a, '0) : '0);
            nvec++;
            if (l2g_full_o !== ((k >= 3) ? 2'b10 : 2'b00)) begin
                nerr++; $display("FAIL full_flag_k%0d got=%b", k, l2g_full_o);
            end
        end
`ifdef HRB_DEFLECT_CNT_EN
        nvec++;
        if (defl_cnt_o !== {16'd1, 16'd0}) begin
            nerr++; $display("FAIL defl_cnt got=%h exp=00010000", defl_cnt_o);
        end
`endif
        port_l_i = '0;
        port_g_i = '0;
        $display("test_full_deflect done");
    endtask

    task automatic test_drain(input flit_t q [4]);
        for (int j = 0; j < 4; j++) begin
            step();
            chk_bus($sformatf("drain_g_j%0d", j), port_g_o, pk(q[j], '0));
            chk_bus($sformatf("drain_l_j%0d", j), port_l_o, '0);
            if (j == 0) begin
                nvec++;
                if (l2g_full_o !== 2'b00) begin
                    nerr++; $display("FAIL drain_full got=%b exp=00", l2g_full_o);
                end
            end
        end
        step();
        chk_bus("drain_empty", port_g_o, '0);
        $display("test_drain done");
    endtask

    task automatic test_eject_inject();
        flit_t l;
        flit_t x1;
        flit_t x2;
        l  = mk(2'd0, 16'h0051);
        x1 = mk(2'd0, 16'h0052);
        x2 = mk(2'd0, 16'h0053);
        port_l_i = pk('0, l);
        port_g_i = pk('0, x1);
        step();
        chk_bus("ej_l_pass", port_l_o, pk('0, l));
        chk_bus("ej_g_t1", port_g_o, '0);
        port_l_i = '0;
        port_g_i = pk('0, x2);
        step();
        port_g_i = '0;
        chk_bus("ej_l_x1", port_l_o, pk('0, x1));
        step();
        chk_bus("ej_l_x2", port_l_o, pk('0, x2));
        step();
        chk_bus("ej_l_empty", port_l_o, '0);
        $display("test_eject_inject done");
    endtask

    task automatic test_back_to_back();
        flit_t a;
        flit_t p;
        flit_t e;
        a = mk(2'd1, 16'h0061);
        p = mk(2'd3, 16'h0062);
        e = mk(2'd0, 16'h0063);
        port_l_i = pk('0, a);
        port_g_i = pk('0, p);
        step();
        chk_bus("b2b_g_p", port_g_o, pk('0, p));
        port_l_i = '0;
        port_g_i = pk('0, e);
        step();
        port_g_i = '0;
        chk_bus("b2b_g_a", port_g_o, pk('0, a));
        chk_bus("b2b_l_0", port_l_o, '0);
        step();
        chk_bus("b2b_l_e", port_l_o, pk('0, e));
        chk_bus("b2b_g_0", port_g_o, '0);
        $display("test_back_to_back done");
    endtask

    task automatic test_mid_reset();
        port_g_i = pk('0, mk(2'd2, 16'h0071));
        port_l_i = pk('0, mk(2'd1, 16'h0072));
        step();
        port_l_i = pk('0, mk(2'd1, 16'h0073));
        step();
        rst = 1'b1;
        port_l_i = '0;
        port_g_i = '0;
        step();
        rst = 1'b0;
        chk_bus("mrst_g_rst", port_g_o, '0);
        step();
        chk_bus("mrst_g_1", port_g_o, '0);
        step();
        chk_bus("mrst_g_2", port_g_o, '0);
        $display("test_mid_reset done");
    endtask

    initial begin
        flit_t q [4];
        rst = 1'b1;
        port_l_i = '0;
        port_g_i = '0;
        test_reset();
        test_cross_ring();
        test_local_pass();
        test_full_deflect(q);
        test_drain(q);
        test_eject_inject();
        test_back_to_back();
        test_mid_reset();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
